// File: rtl/button_debounce.sv
// Button debouncer: a 2-flop synchronizer feeds a four-state qualify FSM with a hold counter.
// Defining BUTTON_DEBOUNCE_GLITCH_EN adds the glitch_cnt port and its saturating counter.
module button_debounce #(
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       bi,
`ifdef BUTTON_DEBOUNCE_GLITCH_EN
    output logic [7:0] glitch_cnt,
`endif
    output logic       bo
);
    localparam int              CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_Low     = 2'd0,
        S_RiseChk = 2'd1,
        S_High    = 2'd2,
        S_FallChk = 2'd3
    } state_e;

    logic          s1_q;
    logic          s2_q;
    logic          bi_s;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          bo_q,    bo_d;

    assign bi_s = s2_q;
    assign bo   = bo_q;

    // Next-state logic: cnt holds the number of consecutive qualifying samples seen.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bo_d    = bo_q;
        case (state_q)
            S_Low: begin
                if (bi_s) begin
                    state_d = S_RiseChk;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            S_RiseChk: begin
                if (!bi_s) begin
                    state_d = S_Low;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_High;
                    bo_d    = 1'b1;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_High: begin
                if (!bi_s) begin
                    state_d = S_FallChk;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            S_FallChk: begin
                if (bi_s) begin
                    state_d = S_High;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_Low;
                    bo_d    = 1'b0;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_Low;
                cnt_d   = CNT_ZERO;
                bo_d    = 1'b0;
            end
        endcase
    end

    // Synchronizer, state, counter and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= S_Low;
            cnt_q   <= CNT_ZERO;
            bo_q    <= 1'b0;
        end else begin
            s1_q    <= bi;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bo_q    <= bo_d;
        end
    end

`ifdef BUTTON_DEBOUNCE_GLITCH_EN
    logic       glitch_evt_s;
    logic [7:0] glitch_q;

    // A glitch is an abort out of either check state; successful qualifications never count.
    always_comb begin
        glitch_evt_s = 1'b0;
        if (state_q == S_RiseChk) begin
            glitch_evt_s = !bi_s;
        end else if (state_q == S_FallChk) begin
            glitch_evt_s = bi_s;
        end else begin
            glitch_evt_s = 1'b0;
        end
    end

    // Saturating glitch counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            glitch_q <= 8'd0;
        end else if (glitch_evt_s && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end else begin
            glitch_q <= glitch_q;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have one parameter: STABLE_CYCLES, default 1000000, the number of consecutive cycles the synchronized input must hold a new level before the output follows (10 ms at 100 MHz).
REQ-002 STABLE_CYCLES SHALL be at least 2, and the counter width SHALL be the minimum width that holds STABLE_CYCLES.
REQ-003 The block SHALL have the port Clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port Rst, input, 1 bit: synchronous active-high reset, sampled on rising Clk.
REQ-005 The block SHALL have the port bi, input, 1 bit: raw asynchronous button level from the board pin.
REQ-006 The block SHALL have the port bo, output, 1 bit: registered debounced button level, which feeds the downstream one-pulse stage.
REQ-007 The block SHALL have the port glitch_cnt, output, 8 bits, only when BUTTON_DEBOUNCE_GLITCH_EN is defined: saturating count of rejected bounces.

Function
REQ-008 bi SHALL pass through a 2-flop synchronizer (s1, s2), and s2 (bi_s) SHALL be the only form of bi used by the FSM.
REQ-009 The FSM SHALL have four states: S_Low (bo=0, stable), S_RiseChk (bo=0, qualifying high), S_High (bo=1, stable) and S_FallChk (bo=1, qualifying low).
REQ-010 In S_Low, bi_s=1 SHALL move the FSM to S_RiseChk with cnt<=1; otherwise it SHALL stay in S_Low with cnt<=0.
REQ-011 In S_RiseChk, bi_s=1 with cnt==STABLE_CYCLES-1 SHALL move the FSM to S_High with bo<=1 and cnt<=0.
REQ-012 In S_RiseChk, bi_s=1 with cnt<STABLE_CYCLES-1 SHALL increment cnt.
REQ-013 In S_RiseChk, bi_s=0 SHALL move the FSM back to S_Low with cnt<=0 and count one glitch.
REQ-014 S_High and S_FallChk SHALL behave as the mirror of REQ-010..013, with the roles of bi_s levels inverted and bo<=0 on qualification.
REQ-015 Latency: with bi held steady after a change, bo SHALL change on the (STABLE_CYCLES+2)th rising Clk, counting the first edge that samples the new bi level as edge 1.
REQ-016 Any input pulse, at bi_s, shorter than STABLE_CYCLES cycles SHALL leave bo unchanged.
REQ-017 bo SHALL change only from a register and SHALL never change combinationally with bi.
REQ-018 The counter SHALL never exceed STABLE_CYCLES-1 and SHALL not wrap.
REQ-019 A glitch SHALL be counted only on an abort out of S_RiseChk or S_FallChk.
REQ-020 glitch_cnt SHALL saturate at 255 and hold there until reset.
REQ-021 When a qualification succeeds, no glitch SHALL be counted.

Reset
REQ-022 With Rst=1 at a rising Clk, s1, s2, cnt and glitch_cnt SHALL be cleared to 0, the state SHALL become S_Low and bo SHALL become 0, overriding all other activity.
REQ-023 If reset is asserted mid-qualification or in S_High, it SHALL abort the operation, and bo SHALL be 0 on the next cycle.
REQ-024 After reset, a button that is still held SHALL re-qualify with the full latency of REQ-015.
REQ-025 The Rst path SHALL contain no asynchronous logic.

Configuration
REQ-026 When BUTTON_DEBOUNCE_GLITCH_EN is defined, the glitch_cnt port and its counter SHALL be present as described in REQ-007, REQ-019, REQ-020 and REQ-021.
REQ-027 When BUTTON_DEBOUNCE_GLITCH_EN is undefined, the port and the counter SHALL be absent, and the behaviour of bo SHALL be identical to the defined case.

Verification (STABLE_CYCLES=4)
REQ-028 Clean press: bi rises before edge 1 and is held -> bo=0 through edge 5, bo=1 after edge 6, glitch_cnt=0.
REQ-029 Bounce: bi high for 3 cycles, then low, then held low -> bo stays 0 throughout and glitch_cnt=1.
REQ-030 Release with bounce: from bo=1, bi shows 0,0,1,0,0,0,0,... -> one glitch counted, and bo=0 exactly 6 edges after the last 1->0 transition is first sampled.
REQ-031 Reset mid-operation: bo=1 with bi held high, then Rst pulsed for 1 cycle -> bo=0 the next cycle, then bo=1 again 6 edges after Rst deasserts.
REQ-032 Saturation: 300 bounce events of 2 cycles each -> glitch_cnt=255, bo=0.
REQ-033 Minimum pulse: bi high for exactly 4 synchronized cycles -> bo=1 for exactly 4 cycles, starting 6 edges after the rise.
